// File: rtl/framebuffer_pkg.sv
// rtl/framebuffer_pkg.sv - shared types, default geometry and width helper for the scanout reader
package framebuffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } state_t;

    localparam int DEF_H_RES     = 640;
    localparam int DEF_V_RES     = 480;
    localparam int DEF_PIX_W     = 16;
    localparam int FRAME_PIXELS  = DEF_H_RES * DEF_V_RES;
    localparam int BYTES_PER_PIX = DEF_PIX_W / 8;

    // Never returns less than 1 so it is always usable as a vector width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(n)) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/framebuffer_scanout_reader_if.sv
// rtl/framebuffer_scanout_reader_if.sv - read-master and pixel-stream bundle of the scanout reader
interface framebuffer_scanout_reader_if #(
    parameter int ADDR_W = 24,
    parameter int PIX_W  = 16
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [PIX_W-1:0]  avm_readdata;
    logic              avm_readdatavalid;

    logic [PIX_W-1:0]  pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_sop;
    logic              pix_eop;

    modport master (
        output avm_address, avm_read,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output pix_data, pix_valid, pix_sop, pix_eop,
        input  pix_ready
    );

    modport slave (
        input  avm_address, avm_read,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  pix_data, pix_valid, pix_sop, pix_eop,
        output pix_ready
    );
endinterface

// File: rtl/framebuffer_scanout_reader_fifo.sv
// rtl/framebuffer_scanout_reader_fifo.sv - show-ahead pixel FIFO; head entry is visible without a pop
module scanout_pixel_fifo
    import framebuffer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int CNT_W = clog2(DEPTH + 1),
    localparam int PTR_W = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;

    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign data_out = mem_q[rd_ptr_q];
    assign pop_ok   = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // The read credit upstream must make a push into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/framebuffer_scanout_reader.sv
// rtl/framebuffer_scanout_reader.sv - fetches one frame per frame_start and streams it as pixels
module framebuffer_scanout_reader
    import framebuffer_pkg::*;
#(
    parameter int H_RES      = DEF_H_RES,
    parameter int V_RES      = DEF_V_RES,
    parameter int ADDR_W     = 24,
    parameter int PIX_W      = DEF_PIX_W,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [ADDR_W-1:0]             fb_base_addr,
    input  logic                          frame_start,
    framebuffer_scanout_reader_if.master  bus,
    output logic                          busy,
    output logic                          frame_overrun
);
    localparam int N_PIX = H_RES * V_RES;
    localparam int BPP   = PIX_W / 8;
    localparam int CNT_W = clog2(N_PIX);
    localparam int OUT_W = clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(N_PIX - 1);
    localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(BPP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BPP - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              read_q, read_d;
    logic              busy_q, busy_d;
    logic              ovr_q, ovr_d;

    logic              accept, push, pop, fifo_empty, credit_ok;
    logic [OUT_W-1:0]  fifo_count;
    int                count_next;

    assign accept = read_q && !bus.avm_waitrequest;
    // Beats with no read outstanding belong to a frame aborted by reset.
    assign push   = bus.avm_readdatavalid && (out_q != '0);
    assign pop    = !fifo_empty && bus.pix_ready;

    scanout_pixel_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .data_in  (bus.avm_readdata),
        .data_out (bus.pix_data),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign bus.pix_valid   = !fifo_empty;
    assign bus.pix_sop     = !fifo_empty && (pix_cnt_q == '0);
    assign bus.pix_eop     = !fifo_empty && (pix_cnt_q == LAST_IDX);
    assign bus.avm_read    = read_q;
    assign bus.avm_address = addr_q;
    assign busy            = busy_q;
    assign frame_overrun   = ovr_q;

    always_comb begin
        state_d    = state_q;
        req_cnt_d  = req_cnt_q;
        pix_cnt_d  = pop ? pix_cnt_q + CNT_W'(1) : pix_cnt_q;
        out_d      = out_q + OUT_W'(accept) - OUT_W'(push);
        addr_d     = addr_q;
        read_d     = read_q;
        busy_d     = busy_q;
        ovr_d      = ovr_q;
        // Credit is judged on next-cycle occupancy because avm_read is registered.
        count_next = int'(fifo_count) + int'(push) - int'(pop);
        credit_ok  = (FIFO_DEPTH - count_next - int'(out_d)) > 0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start && enable) begin
                    state_d   = ST_FETCH;
                    req_cnt_d = '0;
                    pix_cnt_d = '0;
                    addr_d    = fb_base_addr & ALIGN_MASK;
                    read_d    = credit_ok;
                    busy_d    = 1'b1;
                    ovr_d     = 1'b0;
                end
            end
            ST_FETCH: begin
                if (frame_start) begin
                    ovr_d = 1'b1;
                end
                if (!(read_q && bus.avm_waitrequest)) begin
                    read_d = credit_ok;
                end
                if (accept) begin
                    req_cnt_d = req_cnt_q + CNT_W'(1);
                    addr_d    = addr_q + STRIDE;
                    if (req_cnt_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                        read_d  = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (frame_start) begin
                    ovr_d = 1'b1;
                end
                if (pop && (pix_cnt_q == LAST_IDX)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            req_cnt_q <= '0;
            pix_cnt_q <= '0;
            out_q     <= '0;
            addr_q    <= '0;
            read_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_cnt_q <= req_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            out_q     <= out_d;
            addr_q    <= addr_d;
            read_q    <= read_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
        end
    end

endmodule

// File: tb/tb_framebuffer_scanout_reader.sv
// tb/tb_framebuffer_scanout_reader.sv - directed scoreboard bench for the scanout reader
module tb_framebuffer_scanout_reader;
    localparam int H_RES      = 4;
    localparam int V_RES      = 2;
    localparam int ADDR_W     = 24;
    localparam int PIX_W      = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int N_PIX      = H_RES * V_RES;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              frame_start = 1'b0;
    logic [ADDR_W-1:0] fb_base_addr = '0;
    logic              busy;
    logic              frame_overrun;
    logic              rdv = 1'b0;
    logic [PIX_W-1:0]  rdata = '0;

    framebuffer_scanout_reader_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

    assign bus.avm_readdatavalid = rdv;
    assign bus.avm_readdata      = rdata;

    framebuffer_scanout_reader #(
        .H_RES      (H_RES),
        .V_RES      (V_RES),
        .ADDR_W     (ADDR_W),
        .PIX_W      (PIX_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .fb_base_addr  (fb_base_addr),
        .frame_start   (frame_start),
        .bus           (bus),
        .busy          (busy),
        .frame_overrun (frame_overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    typedef struct { logic [PIX_W-1:0] data; int due; } beat_t;
    beat_t             pend_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_pix_q[$];
    int                cyc = 0;
    int                acc_cnt = 0;
    int                lat = 2;

    function automatic logic [PIX_W-1:0] pix_of(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'hC35A;
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // Slave model and stream monitor; nothing else drives on the falling edge.
    always @(negedge clk) begin
        logic [31:0] e;
        rdv   = 1'b0;
        rdata = '0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc + 1) begin
            rdv   = 1'b1;
            rdata = pend_q[0].data;
            void'(pend_q.pop_front());
        end
        if (bus.avm_read && !bus.avm_waitrequest) begin
            acc_cnt = acc_cnt + 1;
            e = (exp_addr_q.size() > 0) ? 32'(exp_addr_q.pop_front()) : 32'hFFFF_FFFF;
            check("read_addr", 32'(bus.avm_address), e);
            pend_q.push_back('{pix_of(bus.avm_address), cyc + 1 + lat});
        end
        if (bus.pix_valid && bus.pix_ready) begin
            e = (exp_pix_q.size() > 0) ? exp_pix_q.pop_front() : 32'hFFFF_FFFF;
            check("pixel_sop_eop_data", {14'd0, bus.pix_sop, bus.pix_eop, bus.pix_data}, e);
        end
    end

    task automatic pulse_fs(input logic [ADDR_W-1:0] base);
        fb_base_addr = base;
        frame_start  = 1'b1;
        @(posedge clk); #1;
        frame_start  = 1'b0;
    endtask

    task automatic start_frame(input logic [ADDR_W-1:0] base);
        logic [ADDR_W-1:0] a;
        acc_cnt = 0;
        for (int i = 0; i < N_PIX; i++) begin
            a = (base & ~ADDR_W'(1)) + ADDR_W'(2 * i);
            exp_addr_q.push_back(a);
            exp_pix_q.push_back({14'd0, (i == 0), (i == N_PIX - 1), pix_of(a)});
        end
        pulse_fs(base);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && busy; i++) begin
            @(posedge clk); #1;
        end
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_pixels_left"}, 32'(exp_pix_q.size()), 32'd0);
        check({tag, "_reads_left"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    initial begin
        bus.avm_waitrequest = 1'b0;
        bus.pix_ready       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_read", 32'(bus.avm_read), 32'd0);
        check("rst_addr", 32'(bus.avm_address), 32'd0);
        check("rst_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_sop", 32'(bus.pix_sop), 32'd0);
        check("rst_eop", 32'(bus.pix_eop), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr", 32'(frame_overrun), 32'd0);
        reset  = 1'b0;
        enable = 1'b1;
        @(posedge clk); #1;

        start_frame(24'h000100);
        check("t1_read_latency", 32'(bus.avm_read), 32'd1);
        check("t1_first_addr", 32'(bus.avm_address), 32'h100);
        check("t1_busy", 32'(busy), 32'd1);
        wait_idle("t1");

        start_frame(24'hFFFFFC);
        wait_idle("t2_wrap");

        bus.pix_ready = 1'b0;
        start_frame(24'h000300);
        repeat (50) @(posedge clk);
        #1;
        check("t3_accepts_capped", 32'(acc_cnt), 32'd4);
        check("t3_read_stalled", 32'(bus.avm_read), 32'd0);
        check("t3_head_sop", 32'(bus.pix_sop), 32'd1);
        bus.pix_ready = 1'b1;
        wait_idle("t3");

        start_frame(24'h000400);
        for (int i = 0; i < 20 && acc_cnt < 2; i++) begin
            @(posedge clk); #1;
        end
        bus.avm_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_addr_held", 32'(bus.avm_address), 32'h404);
            check("t4_read_held", 32'(bus.avm_read), 32'd1);
            @(posedge clk); #1;
        end
        check("t4_no_advance", 32'(acc_cnt), 32'd2);
        bus.avm_waitrequest = 1'b0;
        wait_idle("t4");

        start_frame(24'h000500);
        repeat (2) @(posedge clk);
        #1;
        pulse_fs(24'h000700);
        check("t5_overrun_set", 32'(frame_overrun), 32'd1);
        wait_idle("t5a");
        check("t5_overrun_sticky", 32'(frame_overrun), 32'd1);
        start_frame(24'h000201);
        check("t5_overrun_clear", 32'(frame_overrun), 32'd0);
        check("t5_new_base", 32'(bus.avm_address), 32'h200);
        wait_idle("t5b");

        enable = 1'b0;
        pulse_fs(24'h000900);
        repeat (3) @(posedge clk);
        #1;
        check("dis_busy", 32'(busy), 32'd0);
        check("dis_read", 32'(bus.avm_read), 32'd0);
        check("dis_ovr", 32'(frame_overrun), 32'd0);
        enable = 1'b1;

        lat = 6;
        start_frame(24'h000600);
        for (int i = 0; i < 20 && acc_cnt < 3; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        check("t6_read", 32'(bus.avm_read), 32'd0);
        check("t6_addr", 32'(bus.avm_address), 32'd0);
        check("t6_valid", 32'(bus.pix_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_sop_eop", {30'd0, bus.pix_sop, bus.pix_eop}, 32'd0);
        exp_addr_q.delete();
        exp_pix_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("t6_late_beats_dropped", 32'(bus.pix_valid), 32'd0);
        check("t6_slave_drained", 32'(pend_q.size()), 32'd0);
        lat = 2;
        start_frame(24'h000000);
        wait_idle("t6_next");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
